pmod_ad1_responder: RTL and testbench
=====================================

# pmod_ad1_responder

Synthesizable emulator of the dual-channel PmodAD1 converter (two AD7476-style 12-bit ADCs sharing CS and serial clock). It answers the reader's CS/serial-clock framing by shifting 16-bit words (4 leading zeros plus a 12-bit sample) onto the `dDATA1` and `dDATA2` lines. It lets the sensor-reader path of the drum front end run in hardware-in-loop tests with no physical Pmod attached. It sits on the board side of the reader's pins, and its sample inputs come from a host stimulus source or from its internal pattern generator.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages on the `CS` and `SCLK` inputs (minimum 2).
- `SAMPLE_W`, default 12: sample width.
- `LEAD_ZEROS`, default 4: zero bits sent before the MSB; frame length is `FRAME_W` = `LEAD_ZEROS` + `SAMPLE_W` = 16.
- `CLK` in 1: system clock, 100 MHz.
- `RST` in 1: reset, asynchronous and active-high.
- `CS` in 1: chip select from the reader, active-low, asynchronous to `CLK`.
- `SCLK` in 1: serial clock from the reader (the 12.5 kHz clock), asynchronous to `CLK`.
- `SAMPLE1` in `SAMPLE_W`: next channel-1 sample.
- `SAMPLE2` in `SAMPLE_W`: next channel-2 sample.
- `SAMPLE_VALID` in 1: writes `SAMPLE1`/`SAMPLE2` into the holding register.
- `dDATA1` out 1: serial data, channel 1.
- `dDATA2` out 1: serial data, channel 2.
- `DATA_OE` out 1: data-line output enable; it models the three-state condition of the converter.
- `BUSY` out 1: a frame is in progress.
- `FRAME_DONE` out 1: one-`CLK` pulse after the last bit is shifted.
- `UNDERRUN` out 1: one-`CLK` pulse when a frame starts with no fresh sample.
- `ABORT` out 1: one-`CLK` pulse when `CS` rises before the frame completes.

## Operation
- Synchronizers: `CS` and `SCLK` each pass through `SYNC_STAGES` flops, then an edge-detect flop. The block acts only on the detected edges: `cs_fall`, `cs_rise`, `sclk_fall`.
- Holding register:
  - Written on every `CLK` in which `SAMPLE_VALID` is high, and sets the `fresh` flag.
  - At `cs_fall` it is copied into both shift registers and `fresh` is cleared.
  - If `fresh` is already 0 at `cs_fall`, the previous value is resent and `UNDERRUN` pulses.
- Shift word layout: `{LEAD_ZEROS'b0, sample}`, sent MSB first.
- State machine:
  - IDLE: `DATA_OE`=0, `dDATA*`=0. On `cs_fall`, load the shift registers, drive bit 15, set bit counter to 15 and go to SHIFT.
  - SHIFT: on each `sclk_fall`, shift left and decrement the counter. The 16th `sclk_fall` (counter 0) goes to QUIET and pulses `FRAME_DONE`. On `cs_rise`, go to IDLE and pulse `ABORT`.
  - QUIET: `DATA_OE`=0, `dDATA*`=0, further `sclk_fall` edges are ignored. On `cs_rise`, go to IDLE.
- Simultaneous events:
  - `cs_rise` beats `sclk_fall` in the same cycle.
  - `SAMPLE_VALID` in the same cycle as `cs_fall`: the old holding value is sent; the new value is stored and stays `fresh` for the next frame.
- `BUSY` = (state is SHIFT).
- `DATA_OE` is 1 only in SHIFT.

## Timing
- Reset values: state IDLE; `dDATA1`=`dDATA2`=0; `DATA_OE`=0; `BUSY`=0; `FRAME_DONE`=`UNDERRUN`=`ABORT`=0; holding register 0; `fresh`=0; synchronizers set to `CS`=1, `SCLK`=1.
- Pin-to-data latency: `SYNC_STAGES`+2 `CLK` cycles from a pin edge to the registered `dDATA*` change (4 cycles, 40 ns, at the default).
- Input constraint: `SCLK` high and low phases must each last at least `SYNC_STAGES`+2 `CLK` cycles. Narrower pulses are outside the supported range.
- Data on `dDATA*` is stable for a whole `SCLK` high phase, so the reader may sample on either `SCLK` edge after that phase starts.
- `RST` asserted mid-frame: all outputs return to their reset values immediately (asynchronous). After release the block waits for a fresh `cs_fall`.

## Configuration
- `PMOD_AD1_RESP_PATTERN_EN` defined:
  - A 12-bit internal ramp replaces the sample inputs. Channel 1 = counter; channel 2 = ~counter.
  - The counter increments at every `FRAME_DONE` and wraps from 4095 to 0.
  - `SAMPLE*`/`SAMPLE_VALID` are ignored, `fresh` is always 1 and `UNDERRUN` is never asserted.
- Macro not defined: no pattern generator is built and the inputs behave as described in Operation.

## Structure
- Shared package `pmod_ad1_pkg`: state enum (IDLE, SHIFT, QUIET) and the constants `SAMPLE_W`, `LEAD_ZEROS`, `FRAME_W`, shared with the reader.
- One sub-module, `pmod_sync_edge`: an N-stage synchronizer with rise/fall pulse outputs, instantiated for `CS` and for `SCLK`.

## Test plan
- Load `SAMPLE1`=0xABC, `SAMPLE2`=0x123, then run one 16-clock frame at 12.5 kHz -> `dDATA1` stream 0x0ABC, `dDATA2` stream 0x0123; one `FRAME_DONE`; `DATA_OE` low after the 16th falling edge.
- Two frames with no `SAMPLE_VALID` between them -> the second frame resends 0x0ABC/0x0123 and `UNDERRUN` pulses once at its start.
- Raise `CS` after 7 `SCLK` falls -> `ABORT` pulse, IDLE within `SYNC_STAGES`+2 cycles, no `FRAME_DONE`; the next frame is complete and correct.
- Assert `RST` mid-frame (bit 9) -> all outputs 0 at once; after release, a new `CS` fall gives a full correct frame.
- Apply `SAMPLE_VALID` in the same cycle as `cs_fall`, with new value 0x555 -> the current frame carries the old value, the next frame carries 0x0555 and no `UNDERRUN`.
- With `PMOD_AD1_RESP_PATTERN_EN` defined, run 4097 frames -> channel 1 reads 0..4095 then 0; channel 2 is the complement of channel 1 in every frame.

Source files
------------

// File: rtl/pmod_ad1_pkg.sv
// pmod_ad1_pkg
//   Definitions shared by the PmodAD1 responder and the sensor reader that
//   talks to it.
//   - SAMPLE_W   : converter sample width
//   - LEAD_ZEROS : zero bits sent ahead of the sample MSB
//   - FRAME_W    : total serial word length
//   - state_t    : responder frame state
package pmod_ad1_pkg;

  localparam int SAMPLE_W   = 12;
  localparam int LEAD_ZEROS = 4;
  localparam int FRAME_W    = LEAD_ZEROS + SAMPLE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    QUIET = 2'd2
  } state_t;

endpackage

// File: rtl/pmod_sync_edge.sv
// pmod_sync_edge
//   Brings an asynchronous pin into the clk domain through STAGES flops.
//   A further flop holds the previous synchronized level, and the rise/fall
//   pulses are registered. The pulses therefore appear STAGES+1 cycles after
//   the pin edge, and each lasts one clk cycle.
// Ports:
//   clk      in  : system clock
//   rst      in  : asynchronous active-high reset
//   async_in in  : pin to synchronize
//   rise     out : one-cycle pulse on a synchronized 0->1 transition
//   fall     out : one-cycle pulse on a synchronized 1->0 transition
module pmod_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  // The previous level resets to the same idle value as the chain. This way,
  // leaving reset does not produce a spurious edge.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
    prev_d = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~prev_q;
    fall_d = ~sync_q[STAGES-1] & prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/pmod_ad1_responder.sv
// pmod_ad1_responder
//   Emulates a dual-channel PmodAD1 (two 12-bit AD7476-style converters that
//   share CS and SCLK). On each CS frame it shifts {LEAD_ZEROS zeros, sample}
//   MSB first onto dDATA1/dDATA2. A new bit is presented after each SCLK
//   falling edge.
// Ports:
//   CLK, RST         : 100 MHz system clock, asynchronous active-high reset
//   CS, SCLK         : reader chip select (active low) and serial clock;
//                      both are asynchronous to CLK
//   SAMPLE1/2        : next sample for each channel
//   SAMPLE_VALID     : writes SAMPLE1/2 into the holding register
//   dDATA1/2         : serial data lines
//   DATA_OE          : high while the converter would be driving its outputs
//   BUSY             : a frame is being shifted
//   FRAME_DONE       : one-cycle pulse after the last bit
//   UNDERRUN         : one-cycle pulse when a frame starts with a stale sample
//   ABORT            : one-cycle pulse when CS rises before the frame ends
// Configuration:
//   PMOD_AD1_RESP_PATTERN_EN : when defined, an internal ramp replaces the
//   sample inputs. Channel 1 carries the counter and channel 2 carries its
//   complement.
module pmod_ad1_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_W    = pmod_ad1_pkg::SAMPLE_W,
  parameter int LEAD_ZEROS  = pmod_ad1_pkg::LEAD_ZEROS
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CS,
  input  logic                SCLK,
  input  logic [SAMPLE_W-1:0] SAMPLE1,
  input  logic [SAMPLE_W-1:0] SAMPLE2,
  input  logic                SAMPLE_VALID,
  output logic                dDATA1,
  output logic                dDATA2,
  output logic                DATA_OE,
  output logic                BUSY,
  output logic                FRAME_DONE,
  output logic                UNDERRUN,
  output logic                ABORT
);

  import pmod_ad1_pkg::*;

  localparam int FRAME_LEN = LEAD_ZEROS + SAMPLE_W;
  localparam int CNT_W     = $clog2(FRAME_LEN);

  logic cs_fall, cs_rise, sclk_fall;
  logic cs_rise_unused, sclk_rise_unused;

  pmod_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk      (CLK),
    .rst      (RST),
    .async_in (CS),
    .rise     (cs_rise_unused),
    .fall     (cs_fall)
  );

  pmod_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
    .clk      (CLK),
    .rst      (RST),
    .async_in (SCLK),
    .rise     (sclk_rise_unused),
    .fall     (sclk_fall)
  );

  // The CS synchronizer exposes its rise pulse under a separate name. This
  // keeps the idle-return logic below easy to read.
  assign cs_rise = cs_rise_unused;

  state_t                 state_q, state_d;
  logic [FRAME_LEN-1:0]   shift1_q, shift1_d;
  logic [FRAME_LEN-1:0]   shift2_q, shift2_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   data1_q, data1_d;
  logic                   data2_q, data2_d;
  logic                   oe_q, oe_d;
  logic                   frame_done_q, frame_done_d;
  logic                   underrun_q, underrun_d;
  logic                   abort_q, abort_d;

  // Values that are captured into the shift registers when a frame starts
  logic [SAMPLE_W-1:0]    load1, load2;
  logic                   load_fresh;

`ifdef PMOD_AD1_RESP_PATTERN_EN
  logic [SAMPLE_W-1:0]    pat_q, pat_d;
  logic                   unused_sample_inputs;

  assign unused_sample_inputs = ^{SAMPLE1, SAMPLE2, SAMPLE_VALID};
  assign load1      = pat_q;
  assign load2      = ~pat_q;
  assign load_fresh = 1'b1;

  // The ramp advances once per completed frame and wraps naturally
  always_comb begin
    pat_d = pat_q;
    if (frame_done_d) begin
      pat_d = pat_q + SAMPLE_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pat_q <= '0;
    end else begin
      pat_q <= pat_d;
    end
  end
`else
  logic [SAMPLE_W-1:0]    hold1_q, hold1_d;
  logic [SAMPLE_W-1:0]    hold2_q, hold2_d;
  logic                   fresh_q, fresh_d;

  assign load1      = hold1_q;
  assign load2      = hold2_q;
  assign load_fresh = fresh_q;

  // A write takes priority over the clear at frame start. A sample that
  // arrives in the same cycle as cs_fall therefore stays fresh for the next
  // frame, while the frame being started takes the old value.
  always_comb begin
    hold1_d = hold1_q;
    hold2_d = hold2_q;
    fresh_d = fresh_q;
    if (state_q == IDLE && cs_fall) begin
      fresh_d = 1'b0;
    end
    if (SAMPLE_VALID) begin
      hold1_d = SAMPLE1;
      hold2_d = SAMPLE2;
      fresh_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold1_q <= '0;
      hold2_q <= '0;
      fresh_q <= 1'b0;
    end else begin
      hold1_q <= hold1_d;
      hold2_q <= hold2_d;
      fresh_q <= fresh_d;
    end
  end
`endif

  // Frame state machine. The serial outputs are computed from the next state
  // and registered. This way, dDATA and DATA_OE change together and are
  // free of glitches on the pins.
  always_comb begin
    state_d      = state_q;
    shift1_d     = shift1_q;
    shift2_d     = shift2_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    abort_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = SHIFT;
          shift1_d   = {{LEAD_ZEROS{1'b0}}, load1};
          shift2_d   = {{LEAD_ZEROS{1'b0}}, load2};
          cnt_d      = CNT_W'(FRAME_LEN - 1);
          underrun_d = ~load_fresh;
        end
      end
      SHIFT: begin
        // CS rising takes priority over a simultaneous SCLK fall
        if (cs_rise) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (sclk_fall) begin
          if (cnt_q == '0) begin
            state_d      = QUIET;
            frame_done_d = 1'b1;
          end else begin
            shift1_d = {shift1_q[FRAME_LEN-2:0], 1'b0};
            shift2_d = {shift2_q[FRAME_LEN-2:0], 1'b0};
            cnt_d    = cnt_q - CNT_W'(1);
          end
        end
      end
      QUIET: begin
        if (cs_rise) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    oe_d    = (state_d == SHIFT);
    data1_d = (state_d == SHIFT) && shift1_d[FRAME_LEN-1];
    data2_d = (state_d == SHIFT) && shift2_d[FRAME_LEN-1];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      shift1_q     <= '0;
      shift2_q     <= '0;
      cnt_q        <= '0;
      data1_q      <= 1'b0;
      data2_q      <= 1'b0;
      oe_q         <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift1_q     <= shift1_d;
      shift2_q     <= shift2_d;
      cnt_q        <= cnt_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      oe_q         <= oe_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
      abort_q      <= abort_d;
    end
  end

  assign dDATA1     = data1_q;
  assign dDATA2     = data2_q;
  assign DATA_OE    = oe_q;
  assign BUSY       = (state_q == SHIFT);
  assign FRAME_DONE = frame_done_q;
  assign UNDERRUN   = underrun_q;
  assign ABORT      = abort_q;

endmodule

// File: tb/tb_pmod_ad1_responder.sv
// tb_pmod_ad1_responder
//   Acts as the reader of the PmodAD1 responder. It drives CS/SCLK frames,
//   keeps a model of the holding register (or of the ramp when
//   PMOD_AD1_RESP_PATTERN_EN is defined), and compares every received word
//   and status pulse with that model.
module tb_pmod_ad1_responder;

  localparam int SW   = 12;
  localparam int FW   = 16;
  localparam int SYNC = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          CS;
  logic          SCLK;
  logic [SW-1:0] SAMPLE1;
  logic [SW-1:0] SAMPLE2;
  logic          SAMPLE_VALID;
  logic          dDATA1, dDATA2, DATA_OE, BUSY, FRAME_DONE, UNDERRUN, ABORT;

  always #5 CLK = ~CLK;

  pmod_ad1_responder #(.SYNC_STAGES(SYNC), .SAMPLE_W(SW), .LEAD_ZEROS(4)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .CS           (CS),
    .SCLK         (SCLK),
    .SAMPLE1      (SAMPLE1),
    .SAMPLE2      (SAMPLE2),
    .SAMPLE_VALID (SAMPLE_VALID),
    .dDATA1       (dDATA1),
    .dDATA2       (dDATA2),
    .DATA_OE      (DATA_OE),
    .BUSY         (BUSY),
    .FRAME_DONE   (FRAME_DONE),
    .UNDERRUN     (UNDERRUN),
    .ABORT        (ABORT)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int underrun_cnt = 0;
  int abort_cnt = 0;
  int ph = 6;

  typedef struct {
    logic [FW-1:0] w1;
    logic [FW-1:0] w2;
    int            underrun;
  } exp_t;

  exp_t exp_q[$];

  logic [SW-1:0] m_hold1 = '0;
  logic [SW-1:0] m_hold2 = '0;
  logic          m_fresh = 1'b0;
`ifdef PMOD_AD1_RESP_PATTERN_EN
  logic [SW-1:0] m_pat = '0;
`endif

  // Pulse outputs last one cycle, so a single sample per cycle counts each
  // of them exactly once
  always @(negedge CLK) begin
    if (FRAME_DONE === 1'b1) done_cnt++;
    if (UNDERRUN === 1'b1) underrun_cnt++;
    if (ABORT === 1'b1) abort_cnt++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic load_sample(input logic [SW-1:0] a, input logic [SW-1:0] b);
    @(negedge CLK);
    SAMPLE1 = a;
    SAMPLE2 = b;
    SAMPLE_VALID = 1'b1;
    @(negedge CLK);
    SAMPLE_VALID = 1'b0;
    m_hold1 = a;
    m_hold2 = b;
    m_fresh = 1'b1;
  endtask

  // Records what the frame that is starting must carry
  task automatic model_start();
    exp_t e;
`ifdef PMOD_AD1_RESP_PATTERN_EN
    e.w1 = {4'b0, m_pat};
    e.w2 = {4'b0, ~m_pat};
    e.underrun = 0;
    m_pat = m_pat + 12'd1;
`else
    e.w1 = {4'b0, m_hold1};
    e.w2 = {4'b0, m_hold2};
    e.underrun = m_fresh ? 0 : 1;
    m_fresh = 1'b0;
`endif
    exp_q.push_back(e);
  endtask

  // Samples each bit during the SCLK high phase, then drives the falling edge
  task automatic shift_frame(input int nfalls, output logic [FW-1:0] c1,
                             output logic [FW-1:0] c2, output logic oe_ok);
    c1 = '0;
    c2 = '0;
    oe_ok = 1'b1;
    for (int i = 0; i < nfalls; i++) begin
      wait_clks(ph);
      c1 = {c1[FW-2:0], dDATA1};
      c2 = {c2[FW-2:0], dDATA2};
      if (DATA_OE !== 1'b1 || BUSY !== 1'b1) oe_ok = 1'b0;
      SCLK = 1'b0;
      wait_clks(ph);
      SCLK = 1'b1;
    end
    wait_clks(ph);
  endtask

  // Runs one complete frame and checks it against the oldest expectation.
  // When same_cycle is set, a new sample is written in the cycle in which
  // cs_fall is detected.
  task automatic full_frame(input string tag, input bit same_cycle,
                            input logic [SW-1:0] n1, input logic [SW-1:0] n2);
    int d0, u0;
    logic [FW-1:0] c1, c2;
    logic oe_ok;
    exp_t e;
    d0 = done_cnt;
    u0 = underrun_cnt;
    @(negedge CLK);
    CS = 1'b0;
    model_start();
    if (same_cycle) begin
      wait_clks(3);
      SAMPLE1 = n1;
      SAMPLE2 = n2;
      SAMPLE_VALID = 1'b1;
      wait_clks(1);
      SAMPLE_VALID = 1'b0;
      m_hold1 = n1;
      m_hold2 = n2;
      m_fresh = 1'b1;
    end
    shift_frame(FW, c1, c2, oe_ok);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (c1 !== e.w1) begin
        errors++;
        $display("[TB] FAIL %s dDATA1 word: got %h expected %h", tag, c1, e.w1);
      end
      checks++;
      if (c2 !== e.w2) begin
        errors++;
        $display("[TB] FAIL %s dDATA2 word: got %h expected %h", tag, c2, e.w2);
      end
      checks++;
      if (underrun_cnt - u0 !== e.underrun) begin
        errors++;
        $display("[TB] FAIL %s UNDERRUN pulses: got %0d expected %0d", tag,
                 underrun_cnt - u0, e.underrun);
      end
    end
    checks++;
    if (oe_ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s DATA_OE/BUSY during frame: got %b expected 1", tag, oe_ok);
    end
    checks++;
    if (DATA_OE !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s after last fall: got OE=%b BUSY=%b expected 0 0", tag, DATA_OE, BUSY);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("[TB] FAIL %s FRAME_DONE pulses: got %0d expected 1", tag, done_cnt - d0);
    end
    CS = 1'b1;
    wait_clks(ph);
  endtask

  task automatic test_reset();
    CS = 1'b1;
    SCLK = 1'b1;
    SAMPLE1 = '0;
    SAMPLE2 = '0;
    SAMPLE_VALID = 1'b0;
    RST = 1'b1;
    wait_clks(3);
    checks++;
    if ({dDATA1, dDATA2, DATA_OE, BUSY, FRAME_DONE, UNDERRUN, ABORT} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold outputs: got %b expected 0000000",
               {dDATA1, dDATA2, DATA_OE, BUSY, FRAME_DONE, UNDERRUN, ABORT});
    end
    RST = 1'b0;
    wait_clks(5);
    checks++;
    if ({dDATA1, dDATA2, DATA_OE, BUSY, FRAME_DONE, UNDERRUN, ABORT} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_release outputs: got %b expected 0000000",
               {dDATA1, dDATA2, DATA_OE, BUSY, FRAME_DONE, UNDERRUN, ABORT});
    end
  endtask

`ifndef PMOD_AD1_RESP_PATTERN_EN
  task automatic test_basic();
    load_sample(12'hABC, 12'h123);
    full_frame("basic", 1'b0, '0, '0);
  endtask

  task automatic test_underrun();
    full_frame("underrun", 1'b0, '0, '0);
  endtask

  task automatic test_abort();
    int a0, d0;
    logic [FW-1:0] c1, c2;
    logic oe_ok;
    load_sample(12'h456, 12'h789);
    a0 = abort_cnt;
    d0 = done_cnt;
    @(negedge CLK);
    CS = 1'b0;
    m_fresh = 1'b0;
    shift_frame(7, c1, c2, oe_ok);
    CS = 1'b1;
    wait_clks(SYNC + 2);
    checks++;
    if (BUSY !== 1'b0 || DATA_OE !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_idle: got BUSY=%b OE=%b expected 0 0", BUSY, DATA_OE);
    end
    wait_clks(2);
    checks++;
    if (abort_cnt - a0 !== 1) begin
      errors++;
      $display("[TB] FAIL abort_pulse: got %0d expected 1", abort_cnt - a0);
    end
    checks++;
    if (done_cnt - d0 !== 0) begin
      errors++;
      $display("[TB] FAIL abort_no_done: got %0d expected 0", done_cnt - d0);
    end
    wait_clks(ph);
    full_frame("after_abort", 1'b0, '0, '0);
  endtask

  task automatic test_reset_mid_frame();
    logic [FW-1:0] c1, c2, w;
    logic oe_ok;
    load_sample(12'h3C5, 12'hA0F);
    w = {4'b0, m_hold1};
    @(negedge CLK);
    CS = 1'b0;
    m_fresh = 1'b0;
    shift_frame(6, c1, c2, oe_ok);
    checks++;
    if (dDATA1 !== w[9]) begin
      errors++;
      $display("[TB] FAIL midframe_bit9: got %b expected %b", dDATA1, w[9]);
    end
    RST = 1'b1;
    #1;
    checks++;
    if ({dDATA1, dDATA2, DATA_OE, BUSY, FRAME_DONE, UNDERRUN, ABORT} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL midframe_reset outputs: got %b expected 0000000",
               {dDATA1, dDATA2, DATA_OE, BUSY, FRAME_DONE, UNDERRUN, ABORT});
    end
    CS = 1'b1;
    wait_clks(3);
    RST = 1'b0;
    m_hold1 = '0;
    m_hold2 = '0;
    m_fresh = 1'b0;
    wait_clks(ph);
    load_sample(12'h3C5, 12'hA0F);
    full_frame("after_reset", 1'b0, '0, '0);
  endtask

  task automatic test_same_cycle();
    load_sample(12'h2AA, 12'h0F0);
    full_frame("same_cycle_old", 1'b1, 12'h555, 12'hAAA);
    full_frame("same_cycle_new", 1'b0, '0, '0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      load_sample(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
      full_frame("back_to_back", 1'b0, '0, '0);
    end
  endtask
`else
  task automatic test_pattern();
    ph = 4;
    for (int i = 0; i < 4097; i++) begin
      full_frame("pattern", 1'b0, '0, '0);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef PMOD_AD1_RESP_PATTERN_EN
    test_basic();
    test_underrun();
    test_abort();
    test_reset_mid_frame();
    test_same_cycle();
    test_back_to_back();
`else
    test_pattern();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
